// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin quantum arbiter.
// Pure definitions; no timing or flow-control behaviour of its own.
package rr_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set candidate at or above ptr, wrapping.
// Zero latency; no backpressure, vld simply reports whether any candidate is set.
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  cand,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [IW-1:0] win_id,
  output logic          vld
);

  logic [N-1:0]  rot;
  logic [IW-1:0] pos;
  logic [IW:0]   sum;

  // Rotating right by ptr puts the highest-priority requester at bit 0.
  assign rot = N'({cand, cand} >> ptr);
  assign vld = |cand;

  always_comb begin
    pos = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) pos = IW'(i);
    end
  end

  always_comb begin
    sum = {1'b0, pos} + {1'b0, ptr};
    if (sum >= (IW + 1)'(N)) sum = sum - (IW + 1)'(N);
  end

  assign win_id = vld ? sum[IW-1:0] : '0;
  assign win    = vld ? (N'(1) << win_id) : '0;

endmodule

// File: rtl/rr_quantum_arbiter.sv
// N-way round-robin arbiter holding each grant for its owner's quantum; 1-cycle req-to-grant.
// Owner releases by dropping req; handover to the next requester is gap-free.
module rr_quantum_arbiter
  import rr_arb_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int QW = 4,
  localparam int IW = idx_w(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N*QW-1:0] quantum,
  output logic [N-1:0]    out,
  output logic [IW-1:0]   gnt_id,
  output logic            busy
);

  state_t        state, state_nx;
  logic [N-1:0]  out_nx;
  logic [IW-1:0] id_nx;
  logic [IW-1:0] ptr, ptr_nx;
  logic [QW-1:0] cnt, cnt_nx;
  logic [N-1:0]  cand, win;
  logic [IW-1:0] win_id;
  logic          win_vld;
  logic          take;
  logic [QW-1:0] q_arr [N];

  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] w);
    return (w == IW'(N - 1)) ? '0 : w + 1'b1;
  endfunction

  // A programmed quantum of 0 behaves as 1 cycle.
  function automatic logic [QW-1:0] hold_load(input logic [QW-1:0] q);
    return (q == '0) ? '0 : q - 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < N; i++) q_arr[i] = quantum[i*QW +: QW];
  end

  // The current owner never competes against itself at handover.
  assign cand = (state == GRANT) ? (req & ~out) : req;

  rr_pick #(.N(N)) u_pick (
    .cand   (cand),
    .ptr    (ptr),
    .win    (win),
    .win_id (win_id),
    .vld    (win_vld)
  );

  always_comb begin
    state_nx = state;
    out_nx   = out;
    id_nx    = gnt_id;
    cnt_nx   = cnt;
    ptr_nx   = ptr;
    take     = 1'b0;
    case (state)
      IDLE: begin
        if (win_vld) take = 1'b1;
      end
      GRANT: begin
        if (!req[gnt_id]) begin
          if (win_vld) begin
            take = 1'b1;
          end else begin
            state_nx = IDLE;
            out_nx   = '0;
            id_nx    = '0;
          end
        end else if (cnt == '0) begin
          if (win_vld) begin
            take = 1'b1;
          end else begin
            cnt_nx = hold_load(q_arr[gnt_id]);
            ptr_nx = next_ptr(gnt_id);
          end
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (take) begin
      state_nx = GRANT;
      out_nx   = win;
      id_nx    = win_id;
      cnt_nx   = hold_load(q_arr[win_id]);
      ptr_nx   = next_ptr(win_id);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      out    <= '0;
      gnt_id <= '0;
      cnt    <= '0;
      ptr    <= '0;
    end else begin
      state  <= state_nx;
      out    <= out_nx;
      gnt_id <= id_nx;
      cnt    <= cnt_nx;
      ptr    <= ptr_nx;
    end
  end

  assign busy = |out;

endmodule

// File: doc/rr_quantum_arbiter.md
# rr_quantum_arbiter

Parametrised N-way round-robin arbiter. Each requester gets a programmable hold time, its quantum, measured in cycles. A grant is held until the owner drops its request or its quantum expires. The grant then rotates to the next requester in round-robin order with no idle bubble. It is the general-width successor to the fixed 4-requester variable-time arbiter and sits in front of shared resources whose ownership lasts multiple cycles.

## Interface
Parameters:
- `N`, 4, number of requesters (≥2)
- `QW`, 4, width of each quantum field in bits

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `req`  in  N  request vector; bit i is requester i
- `quantum`  in  N*QW  per-requester hold time; field i is bits [i*QW +: QW]; value 0 is treated as 1
- `out`  out  N  registered one-hot grant; all-zero when idle
- `gnt_id`  out  $clog2(N)  index of the current owner; 0 when idle
- `busy`  out  1  high while any grant is active (`busy` = |`out`)

## Operation
- State machine: IDLE, GRANT. State, `out`, `gnt_id`, the hold counter `cnt`, and the priority pointer `ptr` are all registers.
- Winner search: the first set bit of the candidate vector, scanning upward from `ptr` and wrapping modulo N.
- On every new grant to requester w:
  - `ptr` ← (w+1) mod N
  - `cnt` ← max(quantum[w],1) − 1
- IDLE:
  - If `req` ≠ 0, grant the winner of `req` and go to GRANT.
  - Otherwise stay in IDLE with `out` = 0.
- GRANT, owner c, evaluated at each edge:
  - **Release** (`req[c]` = 0):
    - If any other request is pending, grant the winner of `req` with bit c masked, at the same edge.
    - Otherwise go to IDLE with `out` = 0.
  - **Expiry** (`req[c]` = 1 and `cnt` = 0):
    - If any other request is pending, grant the winner of `req` with bit c masked.
    - Otherwise re-grant c: `out` is unchanged, `cnt` is reloaded, and `ptr` ← (c+1) mod N.
  - **Hold** (otherwise): `cnt` ← `cnt` − 1; `out` is unchanged.
- `quantum` is sampled only at the grant edge. Changing it mid-grant does not affect the current hold.
- Counter arithmetic is unsigned, QW bits wide, and never decrements below 0.
- Reset mid-grant: the next edge with `rst`=1 drops `out` to 0 regardless of state.

## Timing
- Reset values: state=IDLE, `out`=0, `gnt_id`=0, `busy`=0, `cnt`=0, `ptr`=0.
- Request-to-grant latency is 1 cycle. A `req` sampled at edge k gives `out` valid after edge k.
- A continuously requesting owner with quantum q, with competitors pending, holds `out` for exactly q cycles.
- Handover is gap-free. The old owner's bit clears and the new owner's bit sets on the same edge.
- A release has the same 1-cycle latency. `req[c]` low at edge k means `out[c]` = 0 after edge k.
- `out` is always one-hot or zero. `gnt_id` always matches `out`.

## Structure
- Shared package `rr_arb_pkg` holds:
  - the state enum (IDLE=1'b0, GRANT=1'b1)
  - an index-width helper, $clog2(N)
- Sub-module `rr_pick #(N)` is purely combinational. Inputs are the candidate vector and `ptr`; outputs are a one-hot winner, its index, and a valid flag. Implement it as rotate, priority-encode, then un-rotate.
- Top level contains the FSM, hold counter, pointer, and output registers. It instantiates `rr_pick` once.

## Test plan
All scenarios use N=4, QW=4 and quantum fields {q3,q2,q1,q0} = {4,2,1,3}.
- **Reset:** `rst`=1 for 2 cycles with `req`=4'b1111 → `out`=0, `gnt_id`=0, `busy`=0 throughout. After release, the first grant is `out`=4'b0001.
- **Single hold:** `req`=4'b0001 held for 8 cycles → `out`=4'b0001 for all 8 cycles. The owner is re-granted at expiry with no gap. `req` drops → `out`=0 on the next cycle.
- **Full contention:** `req`=4'b1111 held → grant sequence 0,1,2,3,0 with durations 3,1,2,4 cycles and no zero cycles between grants.
- **Early release:** `req`=4'b0101; requester 0 drops `req` after 1 cycle of grant → `out`=4'b0100 on the next edge. Requester 2 holds for 2 cycles, then requester 0 is granted if it has re-requested.
- **Quantum 0 and mid-grant change:**
  - Set q1=0 with `req`=4'b0010 → `out`=4'b0010 with a 1-cycle quantum.
  - Change q1 to 5 mid-grant → the current hold is unaffected and the next grant uses 5.
- **Reset mid-grant:** during requester 3's 4-cycle hold, assert `rst` for 1 cycle → `out`=0 on the next edge. After `rst` is released with `req`=4'b1000, requester 3 is granted 1 cycle later for a full 4 cycles.
